ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
- Iterative sequencer for RV32M multiply/divide ops resolved in the EX stage.
- Takes the already-forwarded EX operands, runs a 32-iteration shift-add multiply or restoring divide, and holds the pipeline via a stall output until the result is ready.
- Sits beside the EX ALU. Its result replaces ALUResult_ex for M-ops on the done cycle.

Parameters:
- XLEN, 32, operand and result width (only 32 is supported).
- CNT_W, 6, iteration counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_ex  input  1  an M-extension op is valid in EX.
- funct3_ex  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- opA_ex  input  32  forwarded rs1 value.
- opB_ex  input  32  forwarded rs2 value.
- flush_ex  input  1  EX instruction squashed (branch/exception).
- stall_o  output  1  freezes IF/ID/EX registers and inserts a bubble into MEM.
- done_o  output  1  result_o is valid this cycle; the pipeline advances.
- result_o  output  32  M-op result.

Behaviour:
- States: IDLE, CALC, DONE. Reset drives state=IDLE, counter=0, all internal accumulators=0, result_o=0, done_o=0, stall_o=0.
- stall_o = start_ex & ~flush_ex & (state != DONE). This is combinational, so the stall is visible in the same cycle the op enters EX.
- IDLE & start_ex & ~flush_ex:
  - Capture operand magnitudes and sign flags.
    - MULH and DIV/REM treat both operands as signed.
    - MULHSU treats A as signed and B as unsigned.
    - All others are unsigned.
  - Load counter=0.
  - Go to CALC.
  - Special divide cases skip CALC and go straight to DONE, with the result latched this cycle:
    - Divisor zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> opA_ex.
    - Signed overflow (DIV/REM with opA=0x80000000, opB=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- CALC: one iteration per cycle, with counter incrementing each cycle.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring shift-subtract, producing a 32-bit quotient and 32-bit remainder.
  - When counter==31, apply sign fix-up:
    - Multiply: negate the 64-bit product if the signs differ.
    - Divide: quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Latch result_o, then go to DONE.
  - Result select:
    - MUL -> product[31:0].
    - MULH/MULHSU/MULHU -> product[63:32].
    - DIV/DIVU -> quotient.
    - REM/REMU -> remainder.
- DONE: done_o=1, stall_o=0, result_o held. Next state is IDLE unconditionally.
  - A following M-op is accepted in the next cycle, since the pipeline advanced on DONE.
- Latency:
  - Normal op: stall_o is high for 33 cycles (1 IDLE + 32 CALC), and done_o is on cycle 34 counted from the op entering EX.
  - Special divide case: stall_o is high for 1 cycle, and done_o is on cycle 2.
- flush_ex in any state forces IDLE on the next edge. stall_o drops the same cycle, done_o is not asserted, and result_o keeps its previous value.
- start_ex deasserting in CALC without a flush is illegal. The block continues to DONE anyway.
- Operands are sampled only in IDLE. Changes on opA_ex/opB_ex during CALC are ignored.
- Reset asserted mid-op returns immediately (asynchronously) to the reset values above.
- result_o changes only on the transition into DONE, on reset, or via a special-case latch.

Test Plan:
- MUL, opA=7, opB=0xFFFFFFFD (-3), start held -> stall_o high for exactly 33 cycles; done_o pulses 1 cycle on cycle 34; result_o=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14. REMU -> 2. DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). Each takes 34 cycles.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0. In each case stall_o is high 1 cycle and done_o is on cycle 2.
- MUL started, then flush_ex at CALC cycle 10 -> IDLE next edge; stall_o low the same cycle; no done_o; a new DIVU 9/3 issued afterwards -> 3 after 34 cycles.
- rst_n pulsed low mid-CALC -> state IDLE and all outputs 0 asynchronously. Back-to-back MUL,MUL -> second op starts the cycle after the first done_o, and each result is correct.

Source files
------------

// File: rtl/ex_muldiv_seq_if.sv
// EX-stage handshake between the pipeline and the iterative multiply/divide sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface ex_muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start_ex;
   logic [2:0]      funct3_ex;
   logic [XLEN-1:0] opA_ex;
   logic [XLEN-1:0] opB_ex;
   logic            flush_ex;
   logic            stall_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_ex, funct3_ex, opA_ex, opB_ex, flush_ex,
      input  stall_o, done_o, result_o
   );

   modport slave (
      input  start_ex, funct3_ex, opA_ex, opB_ex, flush_ex,
      output stall_o, done_o, result_o
   );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside the EX ALU: 32-step shift-add multiply
// or restoring divide on operand magnitudes, with a sign fix-up on the final step.
//
// state | meaning
// IDLE  | waiting for an M-op in EX; samples operands, resolves divide special cases
// CALC  | one shift-add / shift-subtract iteration per cycle, cnt_q = 0..31
// DONE  | result_o valid, done_o high, pipeline advances; always returns to IDLE
module ex_muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   ex_muldiv_seq_if.slave ex
);
   localparam int W2 = 2 * XLEN;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [XLEN-1:0] mag_q, mag_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [2:0]      op_q, op_d;
   logic            neg_q, neg_d;
   logic            rneg_q, rneg_d;

   logic [2:0]      f;
   logic            sgn_a, sgn_b, div0, ovf;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   mul_sum, div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_sub, quo_fix, rem_fix, calc_res;
   logic [W2-1:0]   mul_next, div_next, step, prod_fix;

   // Operand decode, only consumed in IDLE.
   always_comb begin
      f     = ex.funct3_ex;
      sgn_a = (f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd6) && ex.opA_ex[XLEN-1];
      sgn_b = (f == 3'd1 || f == 3'd4 || f == 3'd6) && ex.opB_ex[XLEN-1];
      mag_a = sgn_a ? -ex.opA_ex : ex.opA_ex;
      mag_b = sgn_b ? -ex.opB_ex : ex.opB_ex;
      div0  = f[2] && (ex.opB_ex == '0);
      ovf   = f[2] && !f[0] && (ex.opA_ex == {1'b1, {(XLEN-1){1'b0}}}) && (ex.opB_ex == '1);
   end

   // acc holds {product_hi, multiplier/product_lo} for multiply and {remainder, quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
      div_ge    = div_shift >= {1'b0, mag_q};
      div_sub   = div_shift[XLEN-1:0] - mag_q;
      div_next  = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                         : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      step      = op_q[2] ? div_next : mul_next;
      prod_fix  = neg_q ? -step : step;
      quo_fix   = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
      rem_fix   = rneg_q ? -step[W2-1:XLEN] : step[W2-1:XLEN];
      if (op_q[2])
         calc_res = op_q[1] ? rem_fix : quo_fix;
      else
         calc_res = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[W2-1:XLEN];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mag_d    = mag_q;
      op_d     = op_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (ex.start_ex && !ex.flush_ex) begin
               op_d   = f;
               neg_d  = sgn_a ^ sgn_b;
               rneg_d = sgn_a;
               cnt_d  = '0;
               if (div0) begin
                  result_d = f[1] ? ex.opA_ex : '1;
                  state_d  = DONE;
               end else if (ovf) begin
                  result_d = f[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                  state_d  = DONE;
               end else begin
                  mag_d   = f[2] ? mag_b : mag_a;
                  acc_d   = {{XLEN{1'b0}}, (f[2] ? mag_a : mag_b)};
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               cnt_d    = '0;
               result_d = calc_res;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A squashed op leaves no trace on result_o.
      if (ex.flush_ex) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mag_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mag_q    <= mag_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign ex.stall_o  = ex.start_ex && !ex.flush_ex && (state_q != DONE);
   assign ex.done_o   = (state_q == DONE);
   assign ex.result_o = result_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: expected results queued at issue, popped on done_o,
// with stall/latency counts checked per op.
module tb_ex_muldiv_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ex_muldiv_seq_if #(.XLEN(32)) bus ();
   ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .ex(bus));

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0]        p;
      logic signed [31:0] sa, sb;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
         3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issues one op with start held; returns at the negedge of its done cycle.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int cyc, st, exp_cyc, exp_st;
      bit spec;
      spec    = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      exp_cyc = spec ? 2 : 34;
      exp_st  = spec ? 1 : 33;
      @(posedge clk);
      #1;
      bus.start_ex  = 1'b1;
      bus.funct3_ex = f;
      bus.opA_ex    = a;
      bus.opB_ex    = b;
      exp_q.push_back(exp);
      cyc = 0;
      st  = 0;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.done_o) break;
         if (bus.stall_o) st++;
         if (cyc == 3) begin
            bus.opA_ex = $urandom;
            bus.opB_ex = $urandom;
         end
      end
      chk({tag, " latency"}, cyc, exp_cyc);
      chk({tag, " stall"}, st, exp_st);
      if (exp_q.size() > 0) chk({tag, " result"}, bus.result_o, exp_q.pop_front());
      last_res = exp;
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      bus.start_ex = 1'b0;
   endtask

   initial begin
      int n_done;
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      bus.start_ex  = 1'b0;
      bus.funct3_ex = '0;
      bus.opA_ex    = '0;
      bus.opB_ex    = '0;
      bus.flush_ex  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset result", bus.result_o, 32'h0);
      chk("reset done", 32'(bus.done_o), 32'h0);
      chk("reset stall", 32'(bus.stall_o), 32'h0);
      rst_n = 1'b1;

      run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      go_idle();
      @(negedge clk);
      chk("done pulse width", 32'(bus.done_o), 32'h0);
      chk("result hold", bus.result_o, 32'hFFFF_FFEB);

      run_op("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
      run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14);
      run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2);
      run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run_op("REM 5/0", 3'd6, 32'd5, 32'd0, 32'd5);
      run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
      run_op("DIVU x/0", 3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
      run_op("REMU x/0", 3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678);
      run_op("MUL -1*-1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
      go_idle();

      // Flush during the tenth CALC cycle.
      @(posedge clk);
      #1;
      bus.start_ex  = 1'b1;
      bus.funct3_ex = 3'd0;
      bus.opA_ex    = 32'd123;
      bus.opB_ex    = 32'd456;
      repeat (11) @(negedge clk);
      bus.flush_ex = 1'b1;
      #1;
      chk("flush stall drop", 32'(bus.stall_o), 32'h0);
      @(posedge clk);
      #1;
      bus.flush_ex = 1'b0;
      bus.start_ex = 1'b0;
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done_o) n_done++;
      end
      chk("flush no done", n_done, 0);
      chk("flush result kept", bus.result_o, last_res);
      run_op("DIVU 9/3", 3'd5, 32'd9, 32'd3, 32'd3);
      go_idle();

      // Asynchronous reset mid-CALC.
      @(posedge clk);
      #1;
      bus.start_ex  = 1'b1;
      bus.funct3_ex = 3'd0;
      bus.opA_ex    = 32'd5;
      bus.opB_ex    = 32'd6;
      repeat (10) @(negedge clk);
      bus.start_ex = 1'b0;
      rst_n        = 1'b0;
      #1;
      chk("async rst result", bus.result_o, 32'h0);
      chk("async rst done", 32'(bus.done_o), 32'h0);
      chk("async rst stall", 32'(bus.stall_o), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done_o) n_done++;
      end
      chk("rst no done", n_done, 0);
      last_res = '0;

      run_op("b2b MUL 1", 3'd0, 32'd6, 32'd7, 32'd42);
      run_op("b2b MUL 2", 3'd0, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500);

      for (int i = 0; i < 10; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         if (i == 4) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         run_op($sformatf("rand%0d f%0d", i, rf), rf, ra, rb, ref_op(rf, ra, rb));
      end
      go_idle();
      @(negedge clk);
      if (exp_q.size() != 0) chk("scoreboard empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
